// File: rtl/blur_pkg.sv
// Shared types and constants for the 3x3 convolutional blur stage.
// Optional feature: GAUSSIAN_KERNEL_EN selects the 1-2-1 Gaussian kernel instead of the box mean.
package blur_pkg;

    localparam int unsigned CHAN_W = 8;

    typedef logic [CHAN_W-1:0] chan_t;

    typedef struct packed {
        chan_t r;
        chan_t g;
        chan_t b;
    } rgb_t;

    typedef rgb_t  [0:2][0:2] win_t;
    typedef chan_t [0:2][0:2] cwin_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    // Reciprocal of 9 in Q0.16; floor(sum*RECIP9 >> 16) == floor(sum/9) for sum <= 2295
    localparam logic [15:0]  RECIP9      = 16'd7282;
    localparam int unsigned  RECIP_SHIFT = 16;

`ifdef GAUSSIAN_KERNEL_EN
    // Separable Gaussian weight table; 2D kernel is the outer product [1 2 1;2 4 2;1 2 1]
    localparam logic [1:0]   KERN_W [0:2] = '{2'd1, 2'd2, 2'd1};
    localparam int unsigned  GAUSS_SHIFT  = 4;
`else
    // Box kernel: unit weights, normalised by the reciprocal multiply
    localparam logic [1:0]   KERN_W [0:2] = '{2'd1, 2'd1, 2'd1};
`endif

endpackage

// File: rtl/blur_chan_pipe.sv
// One colour channel of the blur arithmetic: S1 row sums, S2 total, S3 scale or border bypass.
// Optional feature: GAUSSIAN_KERNEL_EN switches the S3 normalisation to a shift by 4.
module blur_chan_pipe
    import blur_pkg::*;
(
    input  logic  clock,
    input  logic  reset_n,
    input  logic  ld,
    input  logic  bypass,
    input  cwin_t pix_win,
    output chan_t pix_out
);

    logic [9:0]  row_c [0:2];
    logic [9:0]  row_q [0:2];
    logic [11:0] total_c;
    logic [11:0] total_q;
    chan_t       ctr1_q;
    chan_t       ctr2_q;
    chan_t       scaled_c;
    logic        byp1_q;
    logic        byp2_q;

    // Weighted row sums of the window
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            row_c[r] = '0;
            for (int c = 0; c < 3; c++) begin
                row_c[r] = row_c[r] + 10'(KERN_W[c]) * 10'(pix_win[r][c]);
            end
        end
    end

    // Weighted total of the three row sums
    always_comb begin
        total_c = 12'(KERN_W[0]) * 12'(row_q[0])
                + 12'(KERN_W[1]) * 12'(row_q[1])
                + 12'(KERN_W[2]) * 12'(row_q[2]);
    end

    // Normalise the total back to one channel value
    always_comb begin
`ifdef GAUSSIAN_KERNEL_EN
        scaled_c = 8'(total_q >> GAUSS_SHIFT);
`else
        scaled_c = 8'((28'(total_q) * 28'(RECIP9)) >> RECIP_SHIFT);
`endif
    end

    // S1: sample the window on the cycle after the shift strobe
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < 3; r++) row_q[r] <= '0;
            ctr1_q <= '0;
            byp1_q <= 1'b0;
        end else if (ld) begin
            for (int r = 0; r < 3; r++) row_q[r] <= row_c[r];
            ctr1_q <= pix_win[1][1];
            byp1_q <= bypass;
        end
    end

    // S2 and S3: free-running; validity is tracked by the sideband line in the top
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            total_q <= '0;
            ctr2_q  <= '0;
            byp2_q  <= 1'b0;
            pix_out <= '0;
        end else begin
            total_q <= total_c;
            ctr2_q  <= ctr1_q;
            byp2_q  <= byp1_q;
            pix_out <= byp2_q ? ctr2_q : scaled_c;
        end
    end

endmodule

// File: rtl/blur_conv3x3.sv
// 3x3 RGB blur stage behind the line-buffer window: tracks the window centre, bypasses borders,
// flags frame sync errors. Optional feature: GAUSSIAN_KERNEL_EN selects the Gaussian kernel.
module blur_conv3x3
    import blur_pkg::*;
#(
    parameter int unsigned WIDTH        = 640,
    parameter int unsigned HEIGHT       = 480,
    parameter int unsigned CENTER_DELAY = 2*WIDTH+2
)
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        EN,
    input  logic        sof,
    input  win_t        window,
    output logic [23:0] out_pixel,
    output logic        out_valid,
    output logic        out_sof,
    output logic        out_eol,
    output logic        frame_err
);

    localparam int unsigned COL_W     = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int unsigned ROW_W     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int          FRAME_PIX = int'(WIDTH * HEIGHT);
    localparam int          POS_LOAD  = 1 - int'(CENTER_DELAY);

    state_t             state_q, state_d;
    logic signed [31:0] pos_q, pos_next_c;
    logic [COL_W-1:0]   col_q, col_d, col_base_c;
    logic [ROW_W-1:0]   row_q, row_d, row_base_c;
    logic               accept_c, sample_c, err_set_c;
    logic               tag_border_c, tag_sof_c, tag_eol_c;
    logic               en_d_q, tag_v_q, tag_sof_q, tag_eol_q, tag_border_q;
    logic               v1_q, s1_q, e1_q, v2_q, s2_q, e2_q;
    cwin_t              win_r, win_g, win_b;
    chan_t              pix_r, pix_g, pix_b;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next state: FILL before the centre reaches pixel 0, ACTIVE inside the frame, DRAIN after it
    always_comb begin
        state_d = state_q;
        if (accept_c) begin
            if (pos_next_c < 0)              state_d = ST_FILL;
            else if (pos_next_c < FRAME_PIX) state_d = ST_ACTIVE;
            else                             state_d = ST_DRAIN;
        end
    end

    // FSM outputs: event acceptance, next centre position, sample validity, sync error
    always_comb begin
        accept_c  = EN && (sof || (state_q != ST_IDLE));
        err_set_c = EN && sof && ((state_q == ST_FILL) || (state_q == ST_ACTIVE));
        if (sof)                      pos_next_c = POS_LOAD;
        else if (state_q == ST_DRAIN) pos_next_c = pos_q;
        else                          pos_next_c = pos_q + 32'sd1;
        sample_c  = accept_c && (pos_next_c >= 0) && (pos_next_c < FRAME_PIX);
    end

    // Column/row of the sample about to be tagged, and the coordinate after it
    always_comb begin
        col_base_c = sof ? '0 : col_q;
        row_base_c = sof ? '0 : row_q;
        col_d      = col_base_c;
        row_d      = row_base_c;
        if (sample_c) begin
            if (col_base_c == COL_W'(WIDTH-1)) begin
                col_d = '0;
                row_d = (row_base_c == ROW_W'(HEIGHT-1)) ? '0 : row_base_c + ROW_W'(1);
            end else begin
                col_d = col_base_c + COL_W'(1);
            end
        end
        tag_sof_c    = (row_base_c == '0) && (col_base_c == '0);
        tag_eol_c    = (col_base_c == COL_W'(WIDTH-1));
        tag_border_c = (row_base_c == '0) || (row_base_c == ROW_W'(HEIGHT-1)) ||
                       (col_base_c == '0) || tag_eol_c;
    end

    // Position and coordinate counters advance once per accepted EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pos_q <= '0;
            col_q <= '0;
            row_q <= '0;
        end else if (accept_c) begin
            pos_q <= pos_next_c;
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Sideband delay line aligned with the channel pipelines, plus the sticky error flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            en_d_q       <= 1'b0;
            tag_v_q      <= 1'b0;
            tag_sof_q    <= 1'b0;
            tag_eol_q    <= 1'b0;
            tag_border_q <= 1'b0;
            v1_q         <= 1'b0;
            s1_q         <= 1'b0;
            e1_q         <= 1'b0;
            v2_q         <= 1'b0;
            s2_q         <= 1'b0;
            e2_q         <= 1'b0;
            out_valid    <= 1'b0;
            out_sof      <= 1'b0;
            out_eol      <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            en_d_q       <= EN;
            tag_v_q      <= sample_c;
            tag_sof_q    <= sample_c && tag_sof_c;
            tag_eol_q    <= sample_c && tag_eol_c;
            tag_border_q <= tag_border_c;
            v1_q         <= tag_v_q;
            s1_q         <= tag_sof_q;
            e1_q         <= tag_eol_q;
            v2_q         <= v1_q;
            s2_q         <= s1_q;
            e2_q         <= e1_q;
            out_valid    <= v2_q;
            out_sof      <= s2_q;
            out_eol      <= e2_q;
            frame_err    <= frame_err || err_set_c;
        end
    end

    // Split the RGB window into per-channel windows
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                win_r[i][j] = window[i][j].r;
                win_g[i][j] = window[i][j].g;
                win_b[i][j] = window[i][j].b;
            end
        end
    end

    blur_chan_pipe u_pipe_r (.clock(clock), .reset_n(reset_n), .ld(en_d_q), .bypass(tag_border_q),
                             .pix_win(win_r), .pix_out(pix_r));
    blur_chan_pipe u_pipe_g (.clock(clock), .reset_n(reset_n), .ld(en_d_q), .bypass(tag_border_q),
                             .pix_win(win_g), .pix_out(pix_g));
    blur_chan_pipe u_pipe_b (.clock(clock), .reset_n(reset_n), .ld(en_d_q), .bypass(tag_border_q),
                             .pix_win(win_b), .pix_out(pix_b));

    assign out_pixel = {pix_r, pix_g, pix_b};

endmodule

// File: tb/tb_blur_conv3x3.sv
// Directed bench for blur_conv3x3 on an 8x4 frame.
module tb_blur_conv3x3;
    import blur_pkg::*;

    localparam int W      = 8;
    localparam int H      = 4;
    localparam int CD     = 2*W + 2;
    localparam int NFILL  = CD - 1;
    localparam int NPIX   = W * H;
    localparam int NFRAME = NFILL + NPIX + CD;
    localparam int P_UNI  = 0;
    localparam int P_SPEC = 1;
    localparam int P_AC   = 2;

    typedef struct {
        logic [23:0] pix;
        logic        s;
        logic        e;
        int          cyc;
    } obs_t;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        EN      = 1'b0;
    logic        sof     = 1'b0;
    win_t        window  = '0;
    logic [23:0] out_pixel;
    logic        out_valid, out_sof, out_eol, frame_err;

    win_t pend_win = '0;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ev_cyc [0:255];
    obs_t obs_q [$];

    blur_conv3x3 #(.WIDTH(W), .HEIGHT(H), .CENTER_DELAY(CD)) dut (
        .clock(clock), .reset_n(reset_n), .EN(EN), .sof(sof), .window(window),
        .out_pixel(out_pixel), .out_valid(out_valid), .out_sof(out_sof),
        .out_eol(out_eol), .frame_err(frame_err)
    );

    always #5 clock = ~clock;

    // Output recorder, sampled on the falling edge
    always @(negedge clock) begin
        cyc = cyc + 1;
        if (out_valid === 1'b1) obs_q.push_back('{out_pixel, out_sof, out_eol, cyc});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] kern(input int n, input int c);
`ifdef GAUSSIAN_KERNEL_EN
        return 8'((12*n + 4*c) >> 4);
`else
        return 8'((8*n + c) / 9);
`endif
    endfunction

    function automatic win_t gen_win(input int pat, input int k);
        win_t w;
        int a, c;
        a = (k*3) % 256;
        c = (k*5 + 1) % 256;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (pat == P_UNI) begin
                    w[i][j] = '{8'd100, 8'd100, 8'd100};
                end else if (pat == P_SPEC) begin
                    w[i][j].r = 8'(i*3 + j);
                    w[i][j].g = 8'd255;
                    w[i][j].b = (i == 0 && j == 0) ? 8'd254 : 8'd255;
                end else if (i == 1 && j == 1) begin
                    w[i][j] = '{8'(c), 8'((c+3) % 256), 8'(c ^ 165)};
                end else begin
                    w[i][j] = '{8'(a), 8'((a+40) % 256), 8'(255 - a)};
                end
            end
        end
        return w;
    endfunction

    function automatic logic [23:0] exp_ac(input int p);
        int k, a, c, row, col;
        k   = p + NFILL;
        a   = (k*3) % 256;
        c   = (k*5 + 1) % 256;
        row = p / W;
        col = p % W;
        if (row == 0 || row == H-1 || col == 0 || col == W-1)
            return {8'(c), 8'((c+3) % 256), 8'(c ^ 165)};
        return {kern(a, c), kern((a+40) % 256, (c+3) % 256), kern(255-a, c ^ 165)};
    endfunction

    task automatic step(input logic en_i, input logic sof_i, input win_t w);
        @(negedge clock);
        #1;
        window = pend_win;
        EN     = en_i;
        sof    = sof_i;
        if (en_i) pend_win = w;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    task automatic run_frame(input int pat, input int gap, input int n_ev, input logic with_sof);
        for (int k = 0; k < n_ev; k++) begin
            step(1'b1, with_sof && (k == 0), gen_win(pat, k));
            ev_cyc[k] = cyc;
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, '0);
        end
    endtask

    task automatic test_reset();
        idle(3);
        n_checks++;
        if ({out_pixel, out_valid, out_sof, out_eol, frame_err} !== 28'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", {out_pixel, out_valid, out_sof, out_eol, frame_err});
        end
        reset_n = 1'b1;
        idle(3);
        n_checks++;
        if ({out_valid, frame_err} !== 2'b00) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %b expected 00", {out_valid, frame_err});
        end
    endtask

    task automatic test_frame(input int gap, input string tag);
        obs_q.delete();
        run_frame(P_AC, gap, NFRAME, 1'b1);
        idle(6);
        n_checks++;
        if (obs_q.size() != NPIX) begin
            n_fail++;
            $display("FAIL %s_count: got %0d expected %0d", tag, obs_q.size(), NPIX);
        end
        for (int i = 0; i < NPIX; i++) begin
            if (i < obs_q.size()) begin
                n_checks++;
                if (obs_q[i].pix !== exp_ac(i)) begin
                    n_fail++;
                    $display("FAIL %s_pix[%0d]: got %h expected %h", tag, i, obs_q[i].pix, exp_ac(i));
                end
                n_checks++;
                if (obs_q[i].s !== 1'(i == 0)) begin
                    n_fail++;
                    $display("FAIL %s_sof[%0d]: got %b expected %b", tag, i, obs_q[i].s, i == 0);
                end
                n_checks++;
                if (obs_q[i].e !== 1'(i % W == W-1)) begin
                    n_fail++;
                    $display("FAIL %s_eol[%0d]: got %b expected %b", tag, i, obs_q[i].e, i % W == W-1);
                end
                n_checks++;
                if (obs_q[i].cyc != ev_cyc[i+NFILL] + 4) begin
                    n_fail++;
                    $display("FAIL %s_latency[%0d]: got cycle %0d expected %0d", tag, i, obs_q[i].cyc, ev_cyc[i+NFILL] + 4);
                end
            end
        end
        n_checks++;
        if (frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_frame_err: got %b expected 0", tag, frame_err);
        end
    endtask

    task automatic test_uniform();
        obs_q.delete();
        run_frame(P_UNI, 0, NFRAME, 1'b1);
        idle(6);
        n_checks++;
        if (obs_q.size() != NPIX) begin
            n_fail++;
            $display("FAIL uniform_count: got %0d expected %0d", obs_q.size(), NPIX);
        end else begin
            n_checks++;
            if (obs_q[9].pix !== 24'h646464) begin
                n_fail++;
                $display("FAIL uniform_pix: got %h expected 646464", obs_q[9].pix);
            end
            n_checks++;
            if (obs_q[9].cyc != ev_cyc[9+NFILL] + 4) begin
                n_fail++;
                $display("FAIL uniform_latency: got cycle %0d expected %0d", obs_q[9].cyc, ev_cyc[9+NFILL] + 4);
            end
        end
    endtask

    task automatic test_mixed();
        obs_q.delete();
        run_frame(P_SPEC, 0, NFRAME, 1'b1);
        idle(6);
        n_checks++;
        if (obs_q.size() != NPIX) begin
            n_fail++;
            $display("FAIL mixed_count: got %0d expected %0d", obs_q.size(), NPIX);
        end else begin
            n_checks++;
            if (obs_q[9].pix !== 24'h04FFFE) begin
                n_fail++;
                $display("FAIL mixed_interior: got %h expected 04fffe", obs_q[9].pix);
            end
            n_checks++;
            if (obs_q[0].pix !== 24'h04FFFF) begin
                n_fail++;
                $display("FAIL mixed_border: got %h expected 04ffff", obs_q[0].pix);
            end
        end
    endtask

    task automatic test_resync();
        obs_q.delete();
        run_frame(P_UNI, 0, NFILL + 10, 1'b1);
        run_frame(P_UNI, 0, NFRAME, 1'b1);
        idle(6);
        n_checks++;
        if (frame_err !== 1'b1) begin
            n_fail++;
            $display("FAIL resync_frame_err: got %b expected 1", frame_err);
        end
        n_checks++;
        if (obs_q.size() != 10 + NPIX) begin
            n_fail++;
            $display("FAIL resync_count: got %0d expected %0d", obs_q.size(), 10 + NPIX);
        end else begin
            n_checks++;
            if ({obs_q[9].s, obs_q[10].s} !== 2'b01) begin
                n_fail++;
                $display("FAIL resync_sof: got %b expected 01", {obs_q[9].s, obs_q[10].s});
            end
            n_checks++;
            if (obs_q[10].cyc != ev_cyc[NFILL] + 4) begin
                n_fail++;
                $display("FAIL resync_restart: got cycle %0d expected %0d", obs_q[10].cyc, ev_cyc[NFILL] + 4);
            end
        end
    endtask

    task automatic test_reset_mid();
        run_frame(P_UNI, 0, NFILL + 6, 1'b1);
        @(negedge clock);
        #1;
        EN = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_active: got out_valid %b expected 1", out_valid);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({out_pixel, out_valid, out_sof, out_eol, frame_err} !== 28'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %h expected 0", {out_pixel, out_valid, out_sof, out_eol, frame_err});
        end
        @(negedge clock);
        reset_n = 1'b1;
        obs_q.delete();
        run_frame(P_UNI, 0, 40, 1'b0);
        idle(6);
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_no_sof: got %0d outputs expected 0", obs_q.size());
        end
        obs_q.delete();
        run_frame(P_UNI, 0, NFRAME, 1'b1);
        idle(6);
        n_checks++;
        if (obs_q.size() != NPIX) begin
            n_fail++;
            $display("FAIL midreset_frame_count: got %0d expected %0d", obs_q.size(), NPIX);
        end else begin
            n_checks++;
            if (obs_q[0].s !== 1'b1) begin
                n_fail++;
                $display("FAIL midreset_frame_sof: got %b expected 1", obs_q[0].s);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame(0, "frame");
        test_uniform();
        test_mixed();
        test_frame(2, "sparse");
        test_resync();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
